// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   owner_e   : which requester owns the read data returning next cycle
//   DefAddrW  : default byte-address width
//   DefDataW  : default data width
//   cnt_width : width needed to hold 0..max (at least 1 bit)
package dmem_arb_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    function automatic int unsigned cnt_width(input int unsigned max);
        int unsigned w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core port, the DMA port, the data memory and the arbiter.
//   c_*     : core load/store request and return
//   d_*     : DMA/loader request and return
//   m_*     : single-port data memory
// Modports:
//   master  : environment side (core, DMA and memory drive their inputs to the arbiter)
//   slave   : arbiter side
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) ();

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

endinterface

// File: rtl/arb_burst_counter.sv
// Counts consecutive core grants while the DMA is waiting.
//   clk        : clock
//   rst        : synchronous active-high reset
//   inc        : core granted while DMA request pending
//   clr        : DMA granted or no DMA request pending (wins over inc)
//   at_limit   : count has reached MAX_BURST; next grant must go to the DMA
module arb_burst_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CntW = cnt_width(MAX_BURST);
    localparam logic [CntW-1:0] Limit = CntW'(MAX_BURST);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        at_limit = (cnt_q == Limit);
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core load/store port and a DMA port.
// Core has default priority; after MAX_BURST core grants with the DMA waiting, the DMA gets
// one forced grant. One memory access per cycle, read data returns one cycle after the grant.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (core, DMA and memory signals)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    logic   c_pend_q;
    logic   c_pend_d;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    logic   at_limit;
    logic   core_elig;
    logic   core_win;
    logic   dma_win;
    logic   burst_inc;
    logic   burst_clr;
    logic   c_rvalid;
    logic   d_rvalid;

    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst (
        .clk      (clk),
        .rst      (rst),
        .inc      (burst_inc),
        .clr      (burst_clr),
        .at_limit (at_limit)
    );

    always_comb begin
        // A core read returning this cycle is masked so its held request is not reissued.
        core_elig = bus.c_req & ~c_pend_q;
        core_win  = ~rst & core_elig & ~(bus.d_req & at_limit);
        dma_win   = ~rst & bus.d_req & ~core_win;

        burst_inc = core_win & bus.d_req;
        burst_clr = dma_win | ~bus.d_req;

        c_pend_d   = core_win & ~bus.c_we;
        rd_owner_d = OWN_NONE;
        if (core_win && !bus.c_we) begin
            rd_owner_d = OWN_CORE;
        end else if (dma_win && !bus.d_we) begin
            rd_owner_d = OWN_DMA;
        end

        win_addr  = '0;
        win_wdata = '0;
        if (core_win) begin
            win_addr  = bus.c_addr;
            win_wdata = bus.c_wdata;
        end else if (dma_win) begin
            win_addr  = bus.d_addr;
            win_wdata = bus.d_wdata;
        end

        bus.m_en    = core_win | dma_win;
        bus.m_we    = (core_win & bus.c_we) | (dma_win & bus.d_we);
        bus.m_addr  = win_addr;
        bus.m_wdata = win_wdata;

        // Returns are gated during reset so a read in flight at the reset edge is dropped.
        c_rvalid     = ~rst & (rd_owner_q == OWN_CORE);
        d_rvalid     = ~rst & (rd_owner_q == OWN_DMA);
        bus.c_rvalid = c_rvalid;
        bus.d_rvalid = d_rvalid;
        bus.c_rdata  = c_rvalid ? bus.m_rdata : '0;
        bus.d_rdata  = d_rvalid ? bus.m_rdata : '0;
        bus.d_gnt    = dma_win;

        // Stall unless a store is granted now or a load returns now.
        if (rst) begin
            bus.c_stall = bus.c_req;
        end else begin
            bus.c_stall = bus.c_req & ~c_rvalid & ~(core_win & bus.c_we);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_pend_q   <= 1'b0;
            rd_owner_q <= OWN_NONE;
        end else begin
            c_pend_q   <= c_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous memory model.
// Inputs are driven just after the falling edge and outputs sampled 1ns later.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-word memory, one-cycle read latency.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) begin
                mem[bus.m_addr[7:2]] <= bus.m_wdata;
            end else begin
                bus.m_rdata <= mem[bus.m_addr[7:2]];
            end
        end
    end

    task automatic idle_inputs();
        bus.c_req   = 1'b0;
        bus.c_we    = 1'b0;
        bus.c_addr  = '0;
        bus.c_wdata = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic core_store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        idle_inputs();
        bus.c_req   = 1'b1;
        bus.c_we    = 1'b1;
        bus.c_addr  = addr;
        bus.c_wdata = data;
        #1;
        tests++;
        if (bus.c_stall !== 1'b0 || bus.m_we !== 1'b1) begin
            fails++;
            $display("FAIL preload_store addr=%0d stall=%b m_we=%b exp 0/1",
                     addr, bus.c_stall, bus.m_we);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            idle_inputs();
            #1;
            tests++;
            if (bus.m_en !== 1'b0 || bus.c_rvalid !== 1'b0 || bus.d_gnt !== 1'b0 ||
                bus.d_rvalid !== 1'b0 || bus.c_stall !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d m_en=%b c_rvalid=%b d_gnt=%b d_rvalid=%b stall=%b exp all 0",
                         i, bus.m_en, bus.c_rvalid, bus.d_gnt, bus.d_rvalid, bus.c_stall);
            end
        end
        @(negedge clk);
        bus.c_req = 1'b1;
        bus.d_req = 1'b1;
        #1;
        tests++;
        if (bus.c_stall !== 1'b1 || bus.m_en !== 1'b0 || bus.d_gnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_req stall=%b m_en=%b d_gnt=%b exp 1/0/0",
                     bus.c_stall, bus.m_en, bus.d_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_store();
        @(negedge clk);
        idle_inputs();
        bus.c_req   = 1'b1;
        bus.c_we    = 1'b1;
        bus.c_addr  = 32'd100;
        bus.c_wdata = 32'd25;
        #1;
        tests++;
        if (bus.m_en !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'd100 ||
            bus.m_wdata !== 32'd25 || bus.c_stall !== 1'b0) begin
            fails++;
            $display("FAIL store en=%b we=%b addr=%0d wdata=%0d stall=%b exp 1/1/100/25/0",
                     bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.c_stall);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load();
        core_store(32'd96, 32'd7);
        @(negedge clk);
        idle_inputs();
        bus.c_req  = 1'b1;
        bus.c_addr = 32'd96;
        #1;
        tests++;
        if (bus.c_stall !== 1'b1 || bus.m_en !== 1'b1 || bus.m_we !== 1'b0 ||
            bus.m_addr !== 32'd96 || bus.c_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL load_cyc0 stall=%b en=%b we=%b addr=%0d rvalid=%b exp 1/1/0/96/0",
                     bus.c_stall, bus.m_en, bus.m_we, bus.m_addr, bus.c_rvalid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'd7 || bus.c_stall !== 1'b0 ||
            bus.m_en !== 1'b0) begin
            fails++;
            $display("FAIL load_cyc1 rvalid=%b rdata=%0d stall=%b m_en=%b exp 1/7/0/0",
                     bus.c_rvalid, bus.c_rdata, bus.c_stall, bus.m_en);
        end
        @(negedge clk);
        idle_inputs();
        bus.c_req  = 1'b1;
        bus.c_addr = 32'd100;
        #1;
        tests++;
        if (bus.c_rvalid !== 1'b0 || bus.c_stall !== 1'b1 || bus.m_addr !== 32'd100) begin
            fails++;
            $display("FAIL load_next rvalid=%b stall=%b addr=%0d exp 0/1/100",
                     bus.c_rvalid, bus.c_stall, bus.m_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'd25) begin
            fails++;
            $display("FAIL load_store_back rvalid=%b rdata=%0d exp 1/25",
                     bus.c_rvalid, bus.c_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_dma_reads();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_000a;
        vals[1] = 32'h2222_000b;
        vals[2] = 32'h3333_000c;
        for (int i = 0; i < 3; i++) core_store(32'(i * 4), vals[i]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i < 3) begin
                bus.d_req  = 1'b1;
                bus.d_addr = 32'(i * 4);
            end
            #1;
            tests++;
            if (bus.d_gnt !== (i < 3) || (i < 3 && bus.m_addr !== 32'(i * 4))) begin
                fails++;
                $display("FAIL dma_gnt cyc=%0d gnt=%b addr=%0d exp %b/%0d",
                         i, bus.d_gnt, bus.m_addr, (i < 3), i * 4);
            end
            tests++;
            if (bus.d_rvalid !== (i >= 1 && i <= 3) ||
                (i >= 1 && i <= 3 && bus.d_rdata !== vals[(i >= 1) ? i - 1 : 0])) begin
                fails++;
                $display("FAIL dma_rvalid cyc=%0d rvalid=%b rdata=%h", i, bus.d_rvalid,
                         bus.d_rdata);
            end
        end
    endtask

    task automatic test_core_rvalid_dma();
        @(negedge clk);
        idle_inputs();
        bus.c_req  = 1'b1;
        bus.c_addr = 32'd96;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'd4;
        #1;
        tests++;
        if (bus.m_addr !== 32'd96 || bus.d_gnt !== 1'b0 || bus.c_stall !== 1'b1) begin
            fails++;
            $display("FAIL overlap_cyc0 addr=%0d gnt=%b stall=%b exp 96/0/1",
                     bus.m_addr, bus.d_gnt, bus.c_stall);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'd7 || bus.c_stall !== 1'b0 ||
            bus.d_gnt !== 1'b1 || bus.m_addr !== 32'd4) begin
            fails++;
            $display("FAIL overlap_cyc1 rvalid=%b rdata=%0d stall=%b gnt=%b addr=%0d",
                     bus.c_rvalid, bus.c_rdata, bus.c_stall, bus.d_gnt, bus.m_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h2222_000b || bus.c_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL overlap_cyc2 d_rvalid=%b d_rdata=%h c_rvalid=%b exp 1/2222000b/0",
                     bus.d_rvalid, bus.d_rdata, bus.c_rvalid);
        end
    endtask

    task automatic run_burst(input int n, input string tag);
        logic exp_d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.c_req   = 1'b1;
            bus.c_we    = 1'b1;
            bus.c_addr  = 32'd200;
            bus.c_wdata = 32'(i);
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b1;
            bus.d_addr  = 32'd44;
            bus.d_wdata = 32'(i + 100);
            #1;
            exp_d = ((i % 5) == 4);
            tests++;
            if (bus.d_gnt !== exp_d || bus.c_stall !== exp_d ||
                bus.m_addr !== (exp_d ? 32'd44 : 32'd200)) begin
                fails++;
                $display("FAIL %s cyc=%0d gnt=%b stall=%b addr=%0d exp gnt=%b", tag, i,
                         bus.d_gnt, bus.c_stall, bus.m_addr, exp_d);
            end
        end
    endtask

    task automatic test_burst();
        run_burst(10, "burst");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_burst();
        run_burst(3, "pre_rst_burst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (bus.m_en !== 1'b0 || bus.d_gnt !== 1'b0 || bus.c_stall !== 1'b1) begin
            fails++;
            $display("FAIL rst_burst en=%b gnt=%b stall=%b exp 0/0/1",
                     bus.m_en, bus.d_gnt, bus.c_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        run_burst(5, "post_rst_burst");
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'd4;
        #1;
        tests++;
        if (bus.d_gnt !== 1'b1 || bus.m_we !== 1'b0) begin
            fails++;
            $display("FAIL mid_gnt gnt=%b we=%b exp 1/0", bus.d_gnt, bus.m_we);
        end
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        tests++;
        if (bus.d_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_rvalid got=%b exp 0", bus.d_rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.d_rvalid !== 1'b0 || bus.c_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_after_rst d_rvalid=%b c_rvalid=%b exp 0/0",
                     bus.d_rvalid, bus.c_rvalid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_store();
        test_load();
        test_dma_reads();
        test_core_rvalid_dma();
        test_burst();
        test_reset_burst();
        test_reset_mid();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
